// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and the small sigma functions.
// The message-schedule sequencer and the round unit both use this package.
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int BLK_WORDS = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND,
      DONE
   } wsched_state_e;

   function automatic word_t sigma0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic word_t sigma1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_wsched_win.sv
// 16-entry circular window of schedule words.
// One synchronous write port and four combinational read ports, no reset,
// because every entry is overwritten by the LOAD phase before it is read.
module sha256_wsched_win
   import sha256_pkg::*;
(
   input  logic       clock,
   input  logic       i_we,
   input  logic [3:0] i_waddr,
   input  word_t      i_wdata,
   input  logic [3:0] i_raddr0,
   input  logic [3:0] i_raddr1,
   input  logic [3:0] i_raddr2,
   input  logic [3:0] i_raddr3,
   output word_t      o_rdata0,
   output word_t      o_rdata1,
   output word_t      o_rdata2,
   output word_t      o_rdata3
);

   word_t r_mem [BLK_WORDS];

   // Single write port: store one accepted or generated word per cycle.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];
   assign o_rdata3 = r_mem[i_raddr3];

endmodule

// File: rtl/sha256_wsched_ctrl.sv
// SHA-256 message-schedule sequencer.
// Loads 16 message words, streams them through, then generates W[16..ROUNDS-1]
// from a circular window, with ap_start/ap_ready/ap_done/ap_idle block control.
// Optional macro WSCHED_STALL_CNT_EN adds a saturating stall_cycles output.
module sha256_wsched_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64,
   parameter int WORD_W = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ap_start,
   output logic        ap_ready,
   output logic        ap_done,
   output logic        ap_idle,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_idx,
   output logic        w_valid,
   input  logic        w_ready
`ifdef WSCHED_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   if (WORD_W != 32) begin : gBadWordWidth
      $error("sha256_wsched_ctrl: WORD_W must be 32");
   end
   if (ROUNDS < 17 || ROUNDS > 64) begin : gBadRounds
      $error("sha256_wsched_ctrl: ROUNDS must be in 17..64");
   end

   wsched_state_e r_state;
   wsched_state_e w_stateNext;
   logic [6:0]    r_t;
   logic [6:0]    w_tNext;

   logic          w_winWe;
   word_t         w_winWdata;
   logic [3:0]    w_tLow;
   word_t         w_rdM2;
   word_t         w_rdM7;
   word_t         w_rdM15;
   word_t         w_rdM16;
   word_t         w_expand;

   assign w_tLow = r_t[3:0];
   assign w_idx  = r_t[5:0];

   sha256_wsched_win uWin (
      .clock    (clock),
      .i_we     (w_winWe),
      .i_waddr  (w_tLow),
      .i_wdata  (w_winWdata),
      .i_raddr0 (w_tLow - 4'd2),
      .i_raddr1 (w_tLow - 4'd7),
      .i_raddr2 (w_tLow + 4'd1),
      .i_raddr3 (w_tLow),
      .o_rdata0 (w_rdM2),
      .o_rdata1 (w_rdM7),
      .o_rdata2 (w_rdM15),
      .o_rdata3 (w_rdM16)
   );

   // The slot being overwritten (t & 15) still holds W[t-16], so it doubles as that term.
   assign w_expand = sigma1(w_rdM2) + w_rdM7 + sigma0(w_rdM15) + w_rdM16;

   // State and word-index registers; reset abandons any partial block.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_t     <= 7'd0;
      end else begin
         r_state <= w_stateNext;
         r_t     <= w_tNext;
      end
   end

   // Next-state, handshake and window-write decode for each phase.
   always_comb begin
      w_stateNext = r_state;
      w_tNext     = r_t;
      ap_ready    = 1'b0;
      ap_done     = 1'b0;
      ap_idle     = 1'b0;
      in_ready    = 1'b0;
      w_valid     = 1'b0;
      w_data      = '0;
      w_winWe     = 1'b0;
      w_winWdata  = in_data;
      case (r_state)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               w_stateNext = LOAD;
               w_tNext     = 7'd0;
            end
         end
         LOAD: begin
            w_valid  = in_valid;
            in_ready = w_ready;
            w_data   = in_data;
            if (in_valid && w_ready) begin
               w_winWe    = 1'b1;
               w_winWdata = in_data;
               w_tNext    = r_t + 7'd1;
               if (r_t == 7'(BLK_WORDS - 1)) begin
                  ap_ready    = 1'b1;
                  w_stateNext = EXPAND;
               end
            end
         end
         EXPAND: begin
            w_valid = 1'b1;
            w_data  = w_expand;
            if (w_ready) begin
               w_winWe    = 1'b1;
               w_winWdata = w_expand;
               w_tNext    = r_t + 7'd1;
               if (r_t == 7'(ROUNDS - 1)) begin
                  w_stateNext = DONE;
               end
            end
         end
         DONE: begin
            ap_done     = 1'b1;
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

`ifdef WSCHED_STALL_CNT_EN
   logic [31:0] r_stallCycles;

   // Count back-pressured output cycles for the current block, saturating at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stallCycles <= '0;
      end else if (r_state == IDLE && ap_start) begin
         r_stallCycles <= '0;
      end else if (w_valid && !w_ready && r_stallCycles != 32'hFFFF_FFFF) begin
         r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

   assign stall_cycles = r_stallCycles;
`endif

endmodule
